// File: rtl/fpalu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpalu_pkg
// Brief    : Shared FP32 field constants, class-bit positions and opcodes
//            for the FP32 add/multiply ALU slice.
// Revision : 1.0 - initial release
// ============================================================================
package fpalu_pkg;

    localparam logic [7:0] EXP_MAX  = 8'hFF;
    localparam logic [7:0] BIAS     = 8'd127;
    localparam int         SIGN_BIT = 31;

    localparam int CLS_ZERO = 0;
    localparam int CLS_INF  = 1;
    localparam int CLS_NAN  = 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [2:0]  acls;
        logic [2:0]  bcls;
    } issue_entry_t;

endpackage : fpalu_pkg
`default_nettype wire

// File: rtl/fp32_classify.sv
`default_nettype none
// ============================================================================
// Module   : fp32_classify
// Brief    : Combinational FP32 classifier {nan, inf, zero}; optionally
//            flushes subnormals to signed zero (FPALU_DENORM_FLUSH_EN).
// Revision : 1.0 - initial release
// ============================================================================
module fp32_classify
    import fpalu_pkg::*;
(
    input  logic [31:0] i_value,
    output logic [2:0]  o_cls,
    output logic [31:0] o_value
);

    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic        w_exp_zero;
    logic        w_exp_max;
    logic        w_man_zero;

    assign w_exp      = i_value[30:23];
    assign w_man      = i_value[22:0];
    assign w_exp_zero = (w_exp == 8'h00);
    assign w_exp_max  = (w_exp == EXP_MAX);
    assign w_man_zero = (w_man == 23'd0);

    assign o_cls[CLS_INF] = w_exp_max && w_man_zero;
    assign o_cls[CLS_NAN] = w_exp_max && !w_man_zero;

`ifdef FPALU_DENORM_FLUSH_EN
    // Subnormals collapse to signed zero, so any zero exponent classifies as zero.
    assign o_cls[CLS_ZERO] = w_exp_zero;
    assign o_value         = (w_exp_zero && !w_man_zero) ? {i_value[SIGN_BIT], 31'd0} : i_value;
`else
    assign o_cls[CLS_ZERO] = w_exp_zero && w_man_zero;
    assign o_value         = i_value;
`endif

endmodule : fp32_classify
`default_nettype wire

// File: rtl/fpalu_operand_issue.sv
`default_nettype none
// ============================================================================
// Module   : fpalu_operand_issue
// Brief    : Operand issue FIFO for the FP32 ALU; classifies operands at
//            enqueue. Subnormal flush enabled by FPALU_DENORM_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fpalu_operand_issue
    import fpalu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic                       in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_a,
    output logic [31:0]                out_b,
    output logic                       out_op,
    output logic [TAG_W-1:0]           out_tag,
    output logic [2:0]                 out_acls,
    output logic [2:0]                 out_bcls,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    issue_entry_t       r_mem     [DEPTH];
    logic [TAG_W-1:0]   r_mem_tag [DEPTH];

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [2:0]         w_acls;
    logic [2:0]         w_bcls;
    logic [31:0]        w_a_stored;
    logic [31:0]        w_b_stored;
    issue_entry_t       w_head;

    fp32_classify u_cls_a (
        .i_value (in_a),
        .o_cls   (w_acls),
        .o_value (w_a_stored)
    );

    fp32_classify u_cls_b (
        .i_value (in_b),
        .o_cls   (w_bcls),
        .o_value (w_b_stored)
    );

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    // Storage carries no reset; the empty gate below hides stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]     <= '{a: w_a_stored, b: w_b_stored, op: in_op,
                                     acls: w_acls, bcls: w_bcls};
            r_mem_tag[r_wr_ptr] <= in_tag;
        end
    end

    assign w_head    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign out_tag   = w_empty ? '0 : r_mem_tag[r_rd_ptr];
    assign out_a     = w_head.a;
    assign out_b     = w_head.b;
    assign out_op    = w_head.op;
    assign out_acls  = w_head.acls;
    assign out_bcls  = w_head.bcls;
    assign out_valid = !w_empty;
    assign in_ready  = !w_full;
    assign level     = r_count;

endmodule : fpalu_operand_issue
`default_nettype wire

// File: tb/tb_fpalu_operand_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpalu_operand_issue
// Brief    : Self-checking bench for fpalu_operand_issue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpalu_operand_issue;
    import fpalu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic             op;
        logic [TAG_W-1:0] tag;
        logic [2:0]       acls;
        logic [2:0]       bcls;
    } model_entry_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_a;
    logic [31:0]          in_b;
    logic                 in_op;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_a;
    logic [31:0]          out_b;
    logic                 out_op;
    logic [TAG_W-1:0]     out_tag;
    logic [2:0]           out_acls;
    logic [2:0]           out_bcls;
    logic [$clog2(DEPTH):0] level;

    int total = 0;
    int bad   = 0;
    model_entry_t model_q[$];

    fpalu_operand_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .out_tag   (out_tag),
        .out_acls  (out_acls),
        .out_bcls  (out_bcls),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Class from plain field arithmetic: bit2 nan, bit1 inf, bit0 zero.
    function automatic logic [2:0] ref_cls(input logic [31:0] x);
        int unsigned e = (x / 32'h0080_0000) % 256;
        int unsigned m = x % 32'h0080_0000;
        if (e == 255) return (m == 0) ? 3'b010 : 3'b100;
`ifdef FPALU_DENORM_FLUSH_EN
        if (e == 0) return 3'b001;
`else
        if (e == 0 && m == 0) return 3'b001;
`endif
        return 3'b000;
    endfunction

    function automatic logic [31:0] ref_val(input logic [31:0] x);
`ifdef FPALU_DENORM_FLUSH_EN
        if ((x / 32'h0080_0000) % 256 == 0) return x & 32'h8000_0000;
`endif
        return x;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] s = {$urandom_range(0, 1) == 1, 31'd0};
        case ($urandom_range(0, 5))
            0: return s;
            1: return s | 32'h7F80_0000;
            2: return s | 32'h7F80_0000 | ($urandom_range(1, 32'h7F_FFFF));
            3: return s | $urandom_range(1, 32'h7F_FFFF);
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_all(input string name);
        model_entry_t h;
        int n = model_q.size();
        h = '{a: 0, b: 0, op: 0, tag: 0, acls: 0, bcls: 0};
        if (n > 0) h = model_q[0];
        chk({name, ".in_ready"},  32'(in_ready),  32'(n < DEPTH));
        chk({name, ".out_valid"}, 32'(out_valid), 32'(n > 0));
        chk({name, ".level"},     32'(level),     32'(n));
        chk({name, ".out_a"},     out_a,          h.a);
        chk({name, ".out_b"},     out_b,          h.b);
        chk({name, ".out_op"},    32'(out_op),    32'(h.op));
        chk({name, ".out_tag"},   32'(out_tag),   32'(h.tag));
        chk({name, ".out_acls"},  32'(out_acls),  32'(h.acls));
        chk({name, ".out_bcls"},  32'(out_bcls),  32'(h.bcls));
    endtask

    // Drive one cycle of stimulus at the negedge, update the model at the
    // posedge, then check at the following negedge.
    task automatic cycle(input string name, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic op,
                         input logic [TAG_W-1:0] tag, input logic rdy);
        bit do_push, do_pop;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_tag    = tag;
        out_ready = rdy;
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = rdy && (model_q.size() > 0);
        @(posedge clk);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back('{a: ref_val(a), b: ref_val(b), op: op, tag: tag,
                                         acls: ref_cls(a), bcls: ref_cls(b)});
        @(negedge clk);
        check_all(name);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Basic push into empty FIFO appears next cycle.
        cycle("push1", 1, 32'h3F80_0000, 32'h4000_0000, OP_ADD, 4'd5, 0);
        chk("push1.a_const", out_a, 32'h3F80_0000);
        chk("push1.tag_const", 32'(out_tag), 32'd5);
        cycle("pop1", 0, 0, 0, 0, 0, 1);

        // Fill, refuse fifth push, drain in order.
        for (int i = 0; i < DEPTH; i++)
            cycle("fill", 1, $urandom, $urandom, 1'($urandom), 4'(i + 1), 0);
        chk("full.level", 32'(level), 32'd4);
        chk("full.in_ready", 32'(in_ready), 32'd0);
        cycle("refused", 1, 32'h1234_5678, 32'h1, OP_MUL, 4'hF, 1);
        for (int i = 0; i < DEPTH; i++)
            cycle("drain", 0, 0, 0, 0, 0, 1);
        chk("drain.out_a_zero", out_a, 32'd0);

        // Steady level 2 with simultaneous push and pop, wrapping pointers.
        cycle("lv2a", 1, $urandom, $urandom, OP_ADD, 4'd0, 0);
        cycle("lv2b", 1, $urandom, $urandom, OP_MUL, 4'd1, 0);
        for (int i = 0; i < 8; i++) begin
            cycle("pushpop", 1, rand_fp(), rand_fp(), 1'($urandom), 4'(i + 2), 1);
            chk("pushpop.level2", 32'(level), 32'd2);
        end
        cycle("lv2c", 0, 0, 0, 0, 0, 1);
        cycle("lv2d", 0, 0, 0, 0, 0, 1);

        // Special values.
        cycle("inf_nan", 1, 32'h7F80_0000, 32'h7FC0_0000, OP_MUL, 4'd3, 0);
        chk("inf_nan.acls", 32'(out_acls), 32'b010);
        chk("inf_nan.bcls", 32'(out_bcls), 32'b100);
        cycle("negzero", 1, 32'h8000_0000, 32'h3F80_0000, OP_ADD, 4'd4, 1);
        chk("negzero.acls", 32'(out_acls), 32'b001);
        cycle("denorm", 1, 32'h0000_0001, 32'h8000_0003, OP_ADD, 4'd6, 1);
`ifdef FPALU_DENORM_FLUSH_EN
        chk("denorm.acls", 32'(out_acls), 32'b001);
        chk("denorm.out_a", out_a, 32'h0);
        chk("denorm.out_b", out_b, 32'h8000_0000);
`else
        chk("denorm.acls", 32'(out_acls), 32'b000);
        chk("denorm.out_a", out_a, 32'h0000_0001);
        chk("denorm.out_b", out_b, 32'h8000_0003);
`endif
        cycle("denorm_pop", 0, 0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle("rand", ($urandom_range(0, 3) != 0), rand_fp(), rand_fp(),
                  1'($urandom), 4'($urandom), ($urandom_range(0, 2) == 0));

        // Asynchronous reset mid-stream with three entries queued.
        for (int i = 0; i < DEPTH; i++)
            cycle("predrain", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            cycle("prefill", 1, rand_fp(), rand_fp(), 1'($urandom), 4'(i + 8), 0);
        chk("prefill.level3", 32'(level), 32'd3);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        model_q.delete();
        #1;
        chk("async.out_valid", 32'(out_valid), 32'd0);
        chk("async.level", 32'(level), 32'd0);
        chk("async.in_ready", 32'(in_ready), 32'd1);
        check_all("async");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_reset", 1, 32'h4040_0000, 32'h7F80_0000, OP_MUL, 4'd9, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fpalu_operand_issue
`default_nettype wire
